uart_rx_framed: RTL and testbench

//  Parametrised UART receiver: configurable bit period, data width, parity and stop bits.

---
 rtl/uart_rx_framed_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 58 +++++
 rtl/uart_rx_framed.sv | 155 +++++++++++++++
 tb/tb_uart_rx_framed.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_framed_pkg.sv
// rtl/uart_rx_framed_pkg.sv - shared parity codes, FSM state encoding and vote helper
// Shared between the receiver and the future transmitter so both agree on the
// parity encoding.
package uart_rx_framed_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - RXD synchroniser, 3-sample history, majority vote, bit timer
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   RXD        raw asynchronous serial input
//   clear      restart the bit timer (start edge seen)
//   mid_tick   bit timer is at the middle of the current bit
//   bit_val    majority of the last three synchronised samples
//   fall_edge  synchronised line just went 1 -> 0
//   line_idle  the last three synchronised samples were all 1
module uart_rx_sampler
    import uart_rx_framed_pkg::*;
#(
    parameter int CLKS_PER_BIT = 26,
    parameter int SYNC_STAGES  = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic RXD,
    input  logic clear,
    output logic mid_tick,
    output logic bit_val,
    output logic fall_edge,
    output logic line_idle
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             hist_q;
    logic [CW-1:0]          cnt_q;
    logic                   line;

    assign line = sync_q[SYNC_STAGES-1];

    // Sync chain and history reset to 1 so an idle line is not seen as a start edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '1;
            hist_q <= '1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RXD};
            hist_q <= {hist_q[1:0], line};
            if (clear || cnt_q == LAST)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign fall_edge = hist_q[0] & ~line;
    assign mid_tick  = (cnt_q == MID);
    assign bit_val   = majority3(hist_q);
    assign line_idle = &hist_q;

endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - framed UART receiver with parity/framing/break/overrun flags
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   RXD         asynchronous serial input, idles high
//   DATA        received word, held while VALID
//   VALID       holding register occupied
//   READY       consumer accepts on VALID && READY
//   PARITY_ERR  parity mismatch for DATA (0 when no parity)
//   FRAME_ERR   a stop bit of DATA's frame sampled 0
//   OVERRUN     DATA overwrote an unaccepted word
//   BREAK       one-cycle pulse on break detection
module uart_rx_framed
    import uart_rx_framed_pkg::*;
#(
    parameter int CLKS_PER_BIT = 26,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    input  logic                 READY,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output logic                 BREAK
);

    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
    localparam logic          ODD_INV   = (PARITY == PARITY_ODD);
    localparam logic          HAS_PAR   = (PARITY != PARITY_NONE);

    rx_state_t state_q, state_d;

    logic                 mid_tick, bit_val, fall_edge, line_idle;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 zero_q;   // every bit so far in this frame was 0
    logic                 perr_q;
    logic                 ferr_q;
    logic                 clear_cnt, brk_det, word_done;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .RXD      (RXD),
        .clear    (clear_cnt),
        .mid_tick (mid_tick),
        .bit_val  (bit_val),
        .fall_edge(fall_edge),
        .line_idle(line_idle)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (fall_edge) state_d = ST_START;
            ST_START:    if (mid_tick) state_d = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:     if (mid_tick && idx_q == LAST_DATA)
                             state_d = HAS_PAR ? ST_PARITY : ST_STOP;
            ST_PARITY:   if (mid_tick) state_d = ST_STOP;
            ST_STOP:     if (mid_tick) begin
                             if (brk_det)
                                 state_d = ST_BRK_WAIT;
                             else if (idx_q == LAST_STOP)
                                 state_d = ST_IDLE;
                         end
            ST_BRK_WAIT: if (line_idle) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Break is decided on the first stop bit only; completion is on the last one.
    always_comb begin
        clear_cnt = (state_q == ST_IDLE) && fall_edge;
        brk_det   = (state_q == ST_STOP) && mid_tick && (idx_q == '0) && zero_q && !bit_val;
        word_done = (state_q == ST_STOP) && mid_tick && (idx_q == LAST_STOP) && !brk_det;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q   <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else if (mid_tick) begin
            case (state_q)
                ST_START: begin
                    idx_q  <= '0;
                    zero_q <= 1'b1;
                    perr_q <= 1'b0;
                    ferr_q <= 1'b0;
                end
                ST_DATA: begin
                    shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                    zero_q  <= zero_q & ~bit_val;
                    idx_q   <= (idx_q == LAST_DATA) ? '0 : idx_q + IW'(1);
                end
                ST_PARITY: begin
                    perr_q <= bit_val ^ (^shift_q) ^ ODD_INV;
                    zero_q <= zero_q & ~bit_val;
                end
                ST_STOP: begin
                    ferr_q <= ferr_q | ~bit_val;
                    idx_q  <= idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // One-entry holding register; a completing word always wins over an accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA       <= '0;
            VALID      <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
            BREAK      <= 1'b0;
        end else begin
            BREAK <= brk_det;
            if (word_done) begin
                DATA       <= shift_q;
                VALID      <= 1'b1;
                PARITY_ERR <= HAS_PAR & perr_q;
                FRAME_ERR  <= ferr_q | ~bit_val;
                OVERRUN    <= VALID & ~READY;
            end else if (VALID && READY) begin
                VALID      <= 1'b0;
                PARITY_ERR <= 1'b0;
                FRAME_ERR  <= 1'b0;
                OVERRUN    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - self-checking bench for uart_rx_framed (8N1, 8E1, 8N2)
module tb_uart_rx_framed;
    import uart_rx_framed_pkg::*;

    localparam int BIT = 26;
    localparam int LAT = 2 + (1 + 8 + 0 + 1 - 1) * BIT + BIT / 2 + 1;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par;
        logic       stop2;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rxd   [3];
    logic       ready [3];
    logic [7:0] data_w  [3];
    logic       valid_w [3];
    logic       perr_w  [3];
    logic       ferr_w  [3];
    logic       ovr_w   [3];
    logic       brk_w   [3];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;
    int   rise_cnt [3] = '{0, 0, 0};
    int   rise_cyc [3] = '{0, 0, 0};
    int   high_cnt [3] = '{0, 0, 0};
    int   brk_cnt  [3] = '{0, 0, 0};
    logic prev_valid [3] = '{0, 0, 0};
    exp_t exp_q [$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    uart_rx_framed #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u0 (
        .CLK(CLK), .RST(RST), .RXD(rxd[0]), .DATA(data_w[0]), .VALID(valid_w[0]), .READY(ready[0]),
        .PARITY_ERR(perr_w[0]), .FRAME_ERR(ferr_w[0]), .OVERRUN(ovr_w[0]), .BREAK(brk_w[0]));
    uart_rx_framed #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u1 (
        .CLK(CLK), .RST(RST), .RXD(rxd[1]), .DATA(data_w[1]), .VALID(valid_w[1]), .READY(ready[1]),
        .PARITY_ERR(perr_w[1]), .FRAME_ERR(ferr_w[1]), .OVERRUN(ovr_w[1]), .BREAK(brk_w[1]));
    uart_rx_framed #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)) u2 (
        .CLK(CLK), .RST(RST), .RXD(rxd[2]), .DATA(data_w[2]), .VALID(valid_w[2]), .READY(ready[2]),
        .PARITY_ERR(perr_w[2]), .FRAME_ERR(ferr_w[2]), .OVERRUN(ovr_w[2]), .BREAK(brk_w[2]));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input int s, input logic [7:0] d, input logic par, input logic stop2);
        logic [11:0] bits;
        int n;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
        if (s == 1) begin bits[n] = par; n++; end
        bits[n] = 1'b1; n++;
        if (s == 2) begin bits[n] = stop2; n++; end
        start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            rxd[s] = bits[i];
            tick(BIT);
        end
        rxd[s] = 1'b1;
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.sel = s; e.data = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // Scoreboard: pop an expectation on every accepted word.
    always @(negedge CLK) begin
        for (int s = 0; s < 3; s++) begin
            if (valid_w[s] && !prev_valid[s]) begin
                rise_cnt[s]++;
                rise_cyc[s] = cyc;
            end
            if (valid_w[s]) high_cnt[s]++;
            if (brk_w[s]) brk_cnt[s]++;
            prev_valid[s] = valid_w[s];
            if (valid_w[s] && ready[s]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_sel",  s,          e.sel);
                    check("word_data", data_w[s],  e.data);
                    check("word_perr", perr_w[s],  e.perr);
                    check("word_ferr", ferr_w[s],  e.ferr);
                    check("word_ovr",  ovr_w[s],   e.ovr);
                end
            end
        end
    end

    vec_t vecs [7];
    int   r0, b0, h0, lat;

    initial begin
        for (int s = 0; s < 3; s++) begin rxd[s] = 1'b1; ready[s] = 1'b1; end

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[2] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[3] = '{2, 8'h7E, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1};
        vecs[4] = '{2, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[6] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        tick(5);
        for (int s = 0; s < 3; s++) begin
            check("rst_data",  data_w[s],  0);
            check("rst_valid", valid_w[s], 0);
            check("rst_perr",  perr_w[s],  0);
            check("rst_ferr",  ferr_w[s],  0);
            check("rst_ovr",   ovr_w[s],   0);
            check("rst_brk",   brk_w[s],   0);
        end
        RST = 1'b0;
        tick(5);

        for (int i = 0; i < 7; i++) begin
            h0 = high_cnt[vecs[i].sel];
            push(vecs[i].sel, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0);
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop2);
            drain();
            tick(5);
            check("valid_one_cycle", high_cnt[vecs[i].sel] - h0, 1);
            if (i == 0) begin
                lat = rise_cyc[0] - start_cyc;
                n_checks++;
                if (lat >= LAT - 1 && lat <= LAT + 1)
                    n_pass++;
                else
                    $display("FAIL latency: got %0d expected %0d +/-1", lat, LAT);
            end
        end

        // Short low glitch must not produce a word.
        r0 = rise_cnt[0];
        rxd[0] = 1'b0; tick(8); rxd[0] = 1'b1; tick(60);
        check("glitch_no_valid", rise_cnt[0] - r0, 0);
        push(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        drain();
        tick(5);

        // Overrun: two words with no consumer, then a single READY pulse.
        ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        tick(10);
        check("ovr_valid", valid_w[0], 1);
        check("ovr_data",  data_w[0],  8'h22);
        check("ovr_flag",  ovr_w[0],   1);
        push(0, 8'h22, 1'b0, 1'b0, 1'b1);
        ready[0] = 1'b1;
        tick(1);
        ready[0] = 1'b0;
        check("ovr_valid_drop", valid_w[0], 0);
        drain();
        ready[0] = 1'b1;
        tick(5);

        // Break: line low for 12 bit times.
        r0 = rise_cnt[0];
        b0 = brk_cnt[0];
        rxd[0] = 1'b0; tick(12 * BIT); rxd[0] = 1'b1; tick(60);
        check("break_pulses", brk_cnt[0] - b0, 1);
        check("break_no_valid", rise_cnt[0] - r0, 0);
        push(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        drain();
        tick(5);

        // Reset in the middle of data bit 4.
        r0 = rise_cnt[0];
        rxd[0] = 1'b0; tick(BIT);
        rxd[0] = 1'b1; tick(4 * BIT + BIT / 2);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(1);
        check("rst_mid_state", int'(u0.state_q), int'(ST_IDLE));
        tick(300);
        check("rst_mid_no_valid", rise_cnt[0] - r0, 0);
        check("rst_mid_state_later", int'(u0.state_q), int'(ST_IDLE));
        push(0, 8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h81, 1'b0, 1'b1);
        drain();
        tick(5);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
